// File: rtl/crc_byte_packer.sv
// crc_byte_packer: packs 1..8 handshaked bytes (optionally bit-reflected) into a zero-filled 64-bit word
module crc_byte_packer #(
  parameter int MAX_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             cfg_bytewidth,
  input  logic                   cfg_refin,
  input  logic [7:0]             in_byte,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [8*MAX_BYTES-1:0] out_value,
  output logic [2:0]             out_bytewidth,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] FULL = 2'd2;
  logic [1:0] state;
  logic [2:0] idx, tgt, bw, eff_tgt;
  logic       refl, eff_ref, xfer;
  logic [7:0] rev;
  always_comb begin
    for (int i = 0; i < 8; i++) rev[i] = in_byte[7-i];
  end
  // Config is taken live on the first byte of a word and from the latched copy afterwards
  assign eff_tgt       = state == IDLE ? cfg_bytewidth : tgt;
  assign eff_ref       = state == IDLE ? cfg_refin : refl;
  assign in_ready      = !rst && state != FULL;
  assign xfer          = in_valid && in_ready;
  assign out_valid     = state == FULL;
  assign out_bytewidth = out_valid ? bw : 3'd0;
  assign busy          = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 3'd0;
      tgt       <= 3'd0;
      refl      <= 1'b0;
      bw        <= 3'd0;
      out_value <= '0;
    end else if (xfer) begin
      if (state == IDLE) begin
        tgt  <= cfg_bytewidth;
        refl <= cfg_refin;
      end
      out_value[{idx, 3'b000} +: 8] <= eff_ref ? rev : in_byte;
      bw    <= idx;
      idx   <= idx + 3'd1;
      state <= (idx == eff_tgt || in_last) ? FULL : FILL;
    end else if (out_valid && out_ready) begin
      state     <= IDLE;
      idx       <= 3'd0;
      bw        <= 3'd0;
      out_value <= '0;
    end
  end
endmodule

// File: tb/tb_crc_byte_packer.sv
// tb_crc_byte_packer: directed stimulus with a queue scoreboard checked by an independent output monitor
module tb_crc_byte_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cfg_bytewidth = 3'd0;
  logic        cfg_refin = 1'b0;
  logic [7:0]  in_byte = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [63:0] out_value;
  logic [2:0]  out_bytewidth;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  int tests = 0;
  int fails = 0;
  typedef struct packed { logic [63:0] v; logic [2:0] bw; } exp_t;
  exp_t sb[$];

  crc_byte_packer dut (
    .clk(clk), .rst(rst), .cfg_bytewidth(cfg_bytewidth), .cfg_refin(cfg_refin),
    .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_value(out_value), .out_bytewidth(out_bytewidth), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got 0x%0h expected none", out_value);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("word_value", out_value, e.v);
        chk("word_bytewidth", {61'd0, out_bytewidth}, {61'd0, e.bw});
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic last);
    int n = 0;
    in_byte = b;
    in_last = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic push(input logic [63:0] v, input logic [2:0] bw);
    sb.push_back('{v: v, bw: bw});
  endtask

  task automatic cfg(input logic [2:0] bw, input logic r);
    cfg_bytewidth = bw;
    cfg_refin = r;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_out_value", out_value, 64'd0);
    chk("rst_out_bytewidth", {61'd0, out_bytewidth}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    // 4-byte word, latency of out_valid
    cfg(3'd3, 1'b0);
    push(64'h44332211, 3'd3);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("t1_not_valid_yet", {63'd0, out_valid}, 64'd0);
    send(8'h44, 1'b0);
    chk("t1_valid_latency", {63'd0, out_valid}, 64'd1);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    wait_idle();
    // single reflected byte, in_ready held low until accept
    cfg(3'd0, 1'b1);
    out_ready = 1'b0;
    push(64'h80, 3'd0);
    send(8'h01, 1'b0);
    chk("t2_in_ready_full", {63'd0, in_ready}, 64'd0);
    chk("t2_out_valid", {63'd0, out_valid}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("t2_in_ready_held", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    wait_idle();
    // early close with in_last
    cfg(3'd7, 1'b0);
    push(64'hCCBBAA, 3'd2);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    chk("t3_valid_after_last", {63'd0, out_valid}, 64'd1);
    wait_idle();
    // backpressure with a pending upstream byte
    cfg(3'd1, 1'b0);
    out_ready = 1'b0;
    push(64'h2010, 3'd1);
    push(64'h30, 3'd0);
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    cfg(3'd0, 1'b0);
    in_byte = 8'h30;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t4_value_stable", out_value, 64'h2010);
      chk("t4_in_ready_low", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    send(8'h30, 1'b0);
    wait_idle();
    // reset mid-word discards partial data
    cfg(3'd7, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_rst_value", out_value, 64'd0);
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_rst_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    cfg(3'd1, 1'b0);
    push(64'hA55A, 3'd1);
    send(8'h5A, 1'b0);
    send(8'hA5, 1'b0);
    wait_idle();
    // config changes mid-word are ignored
    cfg(3'd1, 1'b0);
    push(64'h0301, 3'd1);
    send(8'h01, 1'b0);
    cfg(3'd7, 1'b1);
    send(8'h03, 1'b0);
    chk("t6_closed_at_two", {63'd0, out_valid}, 64'd1);
    wait_idle();
    // in_last coinciding with the target count
    cfg(3'd2, 1'b0);
    push(64'hC3B2A1, 3'd2);
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hC3, 1'b1);
    wait_idle();
    // reflection across multiple bytes
    cfg(3'd1, 1'b1);
    push(64'h2C48, 3'd1);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
